ldm_stm_seq: RTL and testbench

Multi-cycle micro-sequencer for block load/store (LDM/STM) instructions. It sits between decode and the three-ported register file. It walks a 16-bit register list one register per cycle, drives the register-file read port (STM) or write port (LDM) together with the data-memory port, and finishes with an optional base-register writeback. While it runs, the main datapath stalls on `busy`.

---
 rtl/ldm_stm_pkg.sv | 21 ++
 rtl/ldm_stm_seq_reglist_scan.sv | 25 ++
 rtl/ldm_stm_seq.sv | 167 ++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Encoded so that {p_bit, u_bit} casts directly to the mode.
    typedef enum logic [1:0] {
        DA = 2'b00,
        IA = 2'b01,
        DB = 2'b10,
        IB = 2'b11
    } addr_mode_t;

endpackage

// File: rtl/ldm_stm_seq_reglist_scan.sv
// Combinational register-list scanner: lowest set bit, its one-hot mask, popcount, empty.
module reglist_scan (
    input  logic [15:0] list_i,
    output logic [3:0]  idx_o,
    output logic [15:0] clr_o,
    output logic [4:0]  cnt_o,
    output logic        empty_o
);

    always_comb begin
        idx_o = '0;
        cnt_o = '0;
        // Scan from the top down so the lowest set bit is written last.
        for (int unsigned i = 0; i < 16; i++) begin
            if (list_i[15 - i]) begin
                idx_o = 4'(15 - i);
            end
            cnt_o = cnt_o + 5'(list_i[i]);
        end
    end

    assign clr_o   = list_i & (~list_i + 16'd1);
    assign empty_o = (list_i == '0);

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM micro-sequencer: walks the register list one register per cycle, then optional base writeback.
module ldm_stm_seq
    import ldm_stm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_load,
    input  logic             p_bit,
    input  logic             u_bit,
    input  logic             w_bit,
    input  logic [3:0]       rn,
    input  logic [WIDTH-1:0] base,
    input  logic [15:0]      reglist,
    output logic             busy,
    output logic             done,
    output logic [3:0]       rf_ra,
    input  logic [WIDTH-1:0] rf_rd,
    output logic             rf_we,
    output logic [3:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             pc_we,
    output logic [WIDTH-1:0] pc_wd,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    seq_state_t       state_q, state_d;
    logic [15:0]      list_q, list_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] final_q, final_d;
    logic             ld_q, ld_d;
    logic             wb_q, wb_d;
    logic [3:0]       rn_q, rn_d;

    logic [15:0]      scan_in;
    logic [3:0]       scan_idx;
    logic [15:0]      scan_clr;
    logic [4:0]       scan_cnt;
    logic             scan_empty;

    addr_mode_t       mode;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] start_addr;
    logic [WIDTH-1:0] step;

    // One scanner serves both roles: popcount of the incoming list in IDLE, selection of the remaining list otherwise.
    assign scan_in = (state_q == IDLE) ? reglist : list_q;

    reglist_scan u_scan (
        .list_i  (scan_in),
        .idx_o   (scan_idx),
        .clr_o   (scan_clr),
        .cnt_o   (scan_cnt),
        .empty_o (scan_empty)
    );

    assign step = WIDTH'(WORD_BYTES);
    assign mode = addr_mode_t'({p_bit, u_bit});
    assign span = WIDTH'(scan_cnt) * step;

    always_comb begin
        start_addr = base;
        case (mode)
            IA: start_addr = base;
            IB: start_addr = base + step;
            DA: start_addr = base - span + step;
            DB: start_addr = base - span;
            default: start_addr = base;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            ld_q    <= 1'b0;
            wb_q    <= 1'b0;
            rn_q    <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            final_q <= final_d;
            ld_q    <= ld_d;
            wb_q    <= wb_d;
            rn_q    <= rn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        list_d   = list_q;
        addr_d   = addr_q;
        final_d  = final_q;
        ld_d     = ld_q;
        wb_d     = wb_q;
        rn_d     = rn_q;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        rf_ra    = '0;
        rf_we    = 1'b0;
        rf_wa    = '0;
        rf_wd    = '0;
        pc_we    = 1'b0;
        pc_wd    = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    list_d  = reglist;
                    ld_d    = is_load;
                    rn_d    = rn;
                    addr_d  = start_addr;
                    final_d = u_bit ? base + span : base - span;
                    // A load of Rn itself takes precedence over the writeback.
                    wb_d    = w_bit && !(is_load && reglist[rn]);
                    state_d = scan_empty ? DONE : XFER;
                end
            end
            XFER: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                if (!ld_q) begin
                    rf_ra  = scan_idx;
                    mem_we = 1'b1;
                    mem_wd = rf_rd;
                end else if (scan_idx == 4'd15) begin
                    pc_we = 1'b1;
                    pc_wd = mem_rd;
                end else begin
                    rf_we = 1'b1;
                    rf_wa = scan_idx;
                    rf_wd = mem_rd;
                end
                list_d = list_q & ~scan_clr;
                addr_d = addr_q + step;
                if (list_d == '0) begin
                    state_d = wb_q ? WB : DONE;
                end
            end
            WB: begin
                rf_we   = 1'b1;
                rf_wa   = rn_q;
                rf_wd   = final_q;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: per-cycle scoreboard built from the transfer rules, plus literal pins.
module tb_ldm_stm_seq;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  rf_ra;
        logic        rf_we;
        logic [3:0]  rf_wa;
        logic [31:0] rf_wd;
        logic        pc_we;
        logic [31:0] pc_wd;
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, is_load, p_bit, u_bit, w_bit;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] reglist;
    logic        busy, done, rf_we, pc_we, mem_en, mem_we;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_rd, rf_wd, pc_wd, mem_addr, mem_wd, mem_rd;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    exp_t exp_q[$];
    exp_t last_seq[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] reg_f(input logic [3:0] i);
        return 32'h1000_0000 + 32'(i) * 32'h111;
    endfunction

    assign rf_rd  = reg_f(rf_ra);
    assign mem_rd = mem_f(mem_addr);

    ldm_stm_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit), .rn(rn), .base(base),
        .reglist(reglist), .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h required %h", nm, $time, act, req);
        end
    endtask

    // Expected per-cycle outputs, starting with the start cycle itself (still idle).
    function automatic void build(input logic ld, input logic p, input logic u, input logic w,
                                  input logic [3:0] rn_v, input logic [31:0] base_v,
                                  input logic [15:0] list_v);
        exp_t r;
        int n;
        logic [31:0] a;
        n = $countones(list_v);
        last_seq.delete();
        r = '0;
        last_seq.push_back(r);
        if (u) a = base_v + (p ? 32'd4 : 32'd0);
        else   a = base_v - 32'(4 * n) + (p ? 32'd0 : 32'd4);
        for (int i = 0; i < 16; i++) begin
            if (list_v[i]) begin
                r = '0;
                r.busy = 1'b1;
                r.mem_en = 1'b1;
                r.mem_addr = a;
                if (!ld) begin
                    r.rf_ra = 4'(i);
                    r.mem_we = 1'b1;
                    r.mem_wd = reg_f(4'(i));
                end else if (i == 15) begin
                    r.pc_we = 1'b1;
                    r.pc_wd = mem_f(a);
                end else begin
                    r.rf_we = 1'b1;
                    r.rf_wa = 4'(i);
                    r.rf_wd = mem_f(a);
                end
                last_seq.push_back(r);
                a = a + 32'd4;
            end
        end
        if (n > 0 && w && !(ld && list_v[rn_v])) begin
            r = '0;
            r.busy = 1'b1;
            r.rf_we = 1'b1;
            r.rf_wa = rn_v;
            r.rf_wd = u ? base_v + 32'(4 * n) : base_v - 32'(4 * n);
            last_seq.push_back(r);
        end
        r = '0;
        r.busy = 1'b1;
        r.done = 1'b1;
        last_seq.push_back(r);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'('0);
            chk("busy",     32'(busy),     32'(e.busy));
            chk("done",     32'(done),     32'(e.done));
            chk("rf_ra",    32'(rf_ra),    32'(e.rf_ra));
            chk("rf_we",    32'(rf_we),    32'(e.rf_we));
            chk("rf_wa",    32'(rf_wa),    32'(e.rf_wa));
            chk("rf_wd",    rf_wd,         e.rf_wd);
            chk("pc_we",    32'(pc_we),    32'(e.pc_we));
            chk("pc_wd",    pc_wd,         e.pc_wd);
            chk("mem_en",   32'(mem_en),   32'(e.mem_en));
            chk("mem_we",   32'(mem_we),   32'(e.mem_we));
            chk("mem_addr", mem_addr,      e.mem_addr);
            chk("mem_wd",   mem_wd,        e.mem_wd);
        end
    end

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic ld, input logic p, input logic u, input logic w,
                         input logic [3:0] rn_v, input logic [31:0] base_v,
                         input logic [15:0] list_v);
        @(posedge clk);
        #2;
        is_load = ld; p_bit = p; u_bit = u; w_bit = w;
        rn = rn_v; base = base_v; reglist = list_v;
        start = 1'b1;
        build(ld, p, u, w, rn_v, base_v, list_v);
        exp_q = last_seq;
        @(posedge clk);
        #2;
        start = 1'b0;
        is_load = ~ld; w_bit = ~w; rn = ~rn_v; base = ~base_v; reglist = ~list_v;
    endtask

    task automatic run(input logic ld, input logic p, input logic u, input logic w,
                       input logic [3:0] rn_v, input logic [31:0] base_v,
                       input logic [15:0] list_v, input bit glitch);
        issue(ld, p, u, w, rn_v, base_v, list_v);
        if (glitch) begin
            start = 1'b1;
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; p_bit = 1'b0; u_bit = 1'b0;
        w_bit = 1'b0; rn = '0; base = '0; reglist = '0;
        #1;
        cmp_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // STM IA, start pulse while busy must be ignored
        run(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h000B, 1'b1);
        chk("t1_len", 32'(last_seq.size()), 32'd6);
        chk("t1_addr0", last_seq[1].mem_addr, 32'h100);
        chk("t1_addr2", last_seq[3].mem_addr, 32'h108);
        chk("t1_ra2", 32'(last_seq[3].rf_ra), 32'd3);
        chk("t1_wb", last_seq[4].rf_wd, 32'h10C);
        chk("t1_wb_rn", 32'(last_seq[4].rf_wa), 32'd13);

        // LDM DB with R15, no writeback; back-to-back with previous
        run(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h200, 16'h8003, 1'b0);
        chk("t2_len", 32'(last_seq.size()), 32'd5);
        chk("t2_addr0", last_seq[1].mem_addr, 32'h1F4);
        chk("t2_addr2", last_seq[3].mem_addr, 32'h1FC);
        chk("t2_pc_we", 32'(last_seq[3].pc_we), 32'd1);

        // LDM IB loading Rn: writeback suppressed
        run(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0004, 1'b1);
        chk("t3_len", 32'(last_seq.size()), 32'd3);
        chk("t3_addr", last_seq[1].mem_addr, 32'h304);

        // Empty list with writeback requested
        run(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h400, 16'h0000, 1'b0);
        chk("t4_len", 32'(last_seq.size()), 32'd2);
        chk("t4_done", 32'(last_seq[1].done), 32'd1);

        // Full list STM DA with decrementing base wrap
        run(1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 32'h0000_003C, 16'hFFFF, 1'b0);
        chk("t5_first", last_seq[1].mem_addr, 32'h0000_0000);
        chk("t5_last", last_seq[16].mem_addr, 32'h0000_003C);
        chk("t5_final", last_seq[17].rf_wd, 32'hFFFF_FFFC);

        // LDM DB crossing zero
        run(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 32'h0000_0008, 16'h0007, 1'b0);
        chk("t6_addr0", last_seq[1].mem_addr, 32'hFFFF_FFFC);
        chk("t6_addr1", last_seq[2].mem_addr, 32'h0000_0000);

        // Reset in the second XFER cycle of a 4-register LDM
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h500, 16'h00F0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_async_we", 32'(rf_we), 32'd0);
        chk("rst_async_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        run(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h600, 16'h00F0, 1'b0);
        chk("t7_len", 32'(last_seq.size()), 32'd7);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
